// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_slice valid/ready pipeline slice.
//
// Contents:
//   PIPE_CNT_W(stages) : width of the occupancy counter. It is sized for the
//                        skid build (2*stages entries), so the port width is
//                        the same in both builds.
package pipe_pkg;

    function automatic int PIPE_CNT_W(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/pipe_slice_stage.sv
// One register stage of pipe_slice.
//
// Build option:
//   PIPE_SLICE_SKID_EN defined   : two-entry stage (main + skid register).
//                                  ready_up_o comes straight from a flop.
//   PIPE_SLICE_SKID_EN undefined : single register. ready_up_o is the clock
//                                  enable of the stage, so it depends
//                                  combinationally on ready_down_i.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset (clears the valid flags only)
//   flush_i      synchronous kill of every beat held in the stage
//   valid_up_i   beat offered by the upstream stage
//   data_up_i    payload of that beat
//   ready_up_o   stage can take a beat this cycle
//   valid_o      stage holds a beat for downstream
//   data_o       payload of that beat
//   ready_down_i downstream takes the beat this cycle
module pipe_slice_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              valid_up_i,
    input  logic [DATA_W-1:0] data_up_i,
    output logic              ready_up_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ready_down_i
);

`ifdef PIPE_SLICE_SKID_EN
    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_xfer, out_xfer;

    always_comb begin
        in_xfer      = valid_up_i & ~skid_valid_q;
        out_xfer     = main_valid_q & ready_down_i;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            // Upstream is blocked while the skid entry is full. When the main
            // entry drains, it refills from the skid entry to keep beats in order.
            if (out_xfer) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || out_xfer) begin
            main_valid_d = in_xfer;
            if (in_xfer) begin
                main_data_d = data_up_i;
            end
        end else if (in_xfer) begin
            // Main entry is stalled, so the accepted beat goes into the skid entry.
            skid_valid_d = 1'b1;
            skid_data_d  = data_up_i;
        end
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
    end

    assign ready_up_o = ~skid_valid_q;
    assign valid_o    = main_valid_q;
    assign data_o     = main_data_q;
`else
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              cke;

    always_comb begin
        cke     = ~valid_q | ready_down_i;
        valid_d = valid_q;
        data_d  = data_q;
        if (cke) begin
            valid_d = valid_up_i;
            // Data only captures real beats, so it stays put across bubbles.
            if (valid_up_i) begin
                data_d = data_up_i;
            end
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign ready_up_o = cke;
    assign valid_o    = valid_q;
    assign data_o     = data_q;
`endif

endmodule

// File: rtl/pipe_slice.sv
// pipe_slice: STAGES cascaded valid/ready register stages carrying a DATA_W
// payload. It has a synchronous flush and a registered occupancy count.
//
// Build option: PIPE_SLICE_SKID_EN selects two-entry skid stages.
//   Defined   : capacity is 2*STAGES and ready_o comes from a flop.
//   Undefined : capacity is STAGES and ready_o depends combinationally on ready_i.
//
// Ports:
//   clk      clock
//   rst_n    synchronous active-low reset
//   flush_i  drop every beat in flight and the beat offered this cycle
//   valid_i  upstream beat valid
//   data_i   upstream payload
//   ready_o  slice accepts a beat (forced high during flush)
//   valid_o  downstream beat valid (registered)
//   data_o   downstream payload (registered)
//   ready_i  downstream accepts
//   count_o  beats currently held (registered)
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STAGES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic                          valid_i,
    input  logic [DATA_W-1:0]             data_i,
    output logic                          ready_o,
    output logic                          valid_o,
    output logic [DATA_W-1:0]             data_o,
    input  logic                          ready_i,
    output logic [PIPE_CNT_W(STAGES)-1:0] count_o
);

    localparam int CNT_W = PIPE_CNT_W(STAGES);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } beat_t;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        beat_t beat_up;
        beat_t beat_q;
        logic  ready_up;
        logic  ready_down;

        if (k == 0) begin : g_head
            assign beat_up = '{valid: valid_i, data: data_i};
        end else begin : g_link
            assign beat_up = g_stage[k-1].beat_q;
        end

        if (k == STAGES - 1) begin : g_tail
            assign ready_down = ready_i;
        end else begin : g_chain
            assign ready_down = g_stage[k+1].ready_up;
        end

        pipe_slice_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush_i      (flush_i),
            .valid_up_i   (beat_up.valid),
            .data_up_i    (beat_up.data),
            .ready_up_o   (ready_up),
            .valid_o      (beat_q.valid),
            .data_o       (beat_q.data),
            .ready_down_i (ready_down)
        );
    end

    assign ready_o = flush_i | g_stage[0].ready_up;
    assign valid_o = g_stage[STAGES-1].beat_q.valid;
    assign data_o  = g_stage[STAGES-1].beat_q.data;

    logic             in_xfer, out_xfer;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        in_xfer  = valid_i & ready_o & ~flush_i;
        out_xfer = valid_o & ready_i;
        count_d  = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
